// File: rtl/pointwise_conv_engine_if.sv
// Stream/ROM bundle of the pointwise convolution engine.
// The engine connects through the slave modport; the feeding side and the ROMs use master.
interface pointwise_conv_engine_if #(
  parameter int DSP_NO = 256,
  parameter int CHIN   = 64,
  parameter int WIDTH  = 16
);
  localparam int AW = $clog2(CHIN);

  logic                    start;
  logic signed [WIDTH-1:0] ifm;
  logic                    ifm_valid;
  logic                    ifm_ready;
  logic [AW-1:0]           w_addr;
  logic signed [WIDTH-1:0] w_data [DSP_NO];
  logic signed [WIDTH-1:0] bias   [DSP_NO];
  logic signed [WIDTH-1:0] ofm    [DSP_NO];
  logic                    ofm_valid;
  logic                    ofm_ready;
  logic                    busy;
  logic                    done;

  modport master (
    output start, ifm, ifm_valid, w_data, bias, ofm_ready,
    input  ifm_ready, w_addr, ofm, ofm_valid, busy, done
  );

  modport slave (
    input  start, ifm, ifm_valid, w_data, bias, ofm_ready,
    output ifm_ready, w_addr, ofm, ofm_valid, busy, done
  );
endinterface

// File: rtl/pointwise_conv_engine.sv
// 1x1 convolution engine: DSP_NO parallel MACs over CHIN input channels per pixel,
// bias, arithmetic rescale and saturation. Define PWCONV_RELU_EN to add ReLU clamping.
module pointwise_conv_engine #(
  parameter int DSP_NO = 256,
  parameter int CHIN   = 64,
  parameter int PIXELS = 256,
  parameter int WIDTH  = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 2*WIDTH + $clog2(CHIN)
) (
  input logic                   clk,
  input logic                   rst,
  pointwise_conv_engine_if.slave bus
);
  localparam int CH_W   = $clog2(CHIN);
  localparam int PX_W   = $clog2(PIXELS);
  localparam int PROD_W = 2*WIDTH;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, OUT = 2'd2, FIN = 2'd3} state_t;

  state_t                  state_r, state_nx_s;
  logic [CH_W-1:0]         ch_r;
  logic [PX_W-1:0]         px_r;
  logic signed [ACC_W-1:0] acc_r  [DSP_NO];
  logic signed [PROD_W-1:0] prod_s [DSP_NO];
  logic signed [ACC_W-1:0] sum_s  [DSP_NO];
  logic signed [ACC_W-1:0] pre_s  [DSP_NO];
  logic signed [ACC_W-1:0] res_s  [DSP_NO];
  logic signed [WIDTH-1:0] ofm_r  [DSP_NO];
  logic ifm_ready_r, ofm_valid_r, busy_r, done_r;
  logic ifm_ready_s, ofm_valid_s, busy_s, done_s;
  logic beat_s, last_ch_s, last_px_s;

  function automatic logic signed [WIDTH-1:0] sat_fn(input logic signed [ACC_W-1:0] r);
    logic signed [WIDTH-1:0] y;
`ifdef PWCONV_RELU_EN
    if (r[ACC_W-1])         y = '0;
    else if (r > SAT_MAX)   y = SAT_MAX[WIDTH-1:0];
    else                    y = r[WIDTH-1:0];
`else
    if (r > SAT_MAX)        y = SAT_MAX[WIDTH-1:0];
    else if (r < SAT_MIN)   y = SAT_MIN[WIDTH-1:0];
    else                    y = r[WIDTH-1:0];
`endif
    return y;
  endfunction

  assign beat_s    = bus.ifm_valid & ifm_ready_r;
  assign last_ch_s = (ch_r == CH_W'(CHIN-1));
  assign last_px_s = (px_r == PX_W'(PIXELS-1));

  // MAC, bias and rescale; the rescaled value includes the product of the current beat
  always_comb begin
    for (int j = 0; j < DSP_NO; j++) begin
      prod_s[j] = PROD_W'(bus.ifm) * PROD_W'(bus.w_data[j]);
      sum_s[j]  = acc_r[j] + ACC_W'(prod_s[j]);
      pre_s[j]  = sum_s[j] + (ACC_W'(bus.bias[j]) <<< FRAC);
      res_s[j]  = pre_s[j] >>> FRAC;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_nx_s;
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: if (bus.start) state_nx_s = ACC;
            else           state_nx_s = IDLE;
      ACC:  if (beat_s && last_ch_s) state_nx_s = OUT;
            else                     state_nx_s = ACC;
      OUT:  if (bus.ofm_ready) state_nx_s = last_px_s ? FIN : ACC;
            else               state_nx_s = OUT;
      FIN:  state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Output decode from the next state so the flags come straight from flops
  always_comb begin
    ifm_ready_s = 1'b0;
    ofm_valid_s = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    case (state_nx_s)
      IDLE: busy_s = 1'b0;
      ACC:  begin ifm_ready_s = 1'b1; busy_s = 1'b1; end
      OUT:  begin ofm_valid_s = 1'b1; busy_s = 1'b1; end
      FIN:  begin done_s      = 1'b1; busy_s = 1'b1; end
      default: busy_s = 1'b0;
    endcase
  end

  // Output flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifm_ready_r <= 1'b0;
      ofm_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      ifm_ready_r <= ifm_ready_s;
      ofm_valid_r <= ofm_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  // Counters, accumulators and output pixel register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_r <= '0;
      px_r <= '0;
      for (int j = 0; j < DSP_NO; j++) begin
        acc_r[j] <= '0;
        ofm_r[j] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: if (bus.start) begin
          ch_r <= '0;
          px_r <= '0;
          for (int j = 0; j < DSP_NO; j++) acc_r[j] <= '0;
        end
        ACC: if (beat_s) begin
          for (int j = 0; j < DSP_NO; j++) acc_r[j] <= sum_s[j];
          if (last_ch_s) begin
            ch_r <= '0;
            for (int j = 0; j < DSP_NO; j++) ofm_r[j] <= sat_fn(res_s[j]);
          end else begin
            ch_r <= ch_r + CH_W'(1'b1);
          end
        end
        OUT: if (bus.ofm_ready) begin
          px_r <= last_px_s ? '0 : px_r + PX_W'(1'b1);
          ch_r <= '0;
          for (int j = 0; j < DSP_NO; j++) acc_r[j] <= '0;
        end
        default: ch_r <= ch_r;
      endcase
    end
  end

  assign bus.ifm_ready = ifm_ready_r;
  assign bus.ofm_valid = ofm_valid_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.w_addr    = ch_r;
  assign bus.ofm       = ofm_r;
endmodule

// File: tb/tb_pointwise_conv_engine.sv
// Directed table-driven bench for pointwise_conv_engine (DSP_NO=2, CHIN=4, PIXELS=2, Q8.8).
module tb_pointwise_conv_engine;
  localparam int DSP_NO = 2;
  localparam int CHIN   = 4;
  localparam int PIXELS = 2;
  localparam int WIDTH  = 16;
  localparam int FRAC   = 8;

`ifdef PWCONV_RELU_EN
  localparam logic [15:0] E1_0 = 16'h0000;
  localparam logic [15:0] E3_1 = 16'h0000;
  localparam logic [15:0] E5_0 = 16'h0000;
  localparam logic [15:0] E6_0 = 16'h0000;
`else
  localparam logic [15:0] E1_0 = 16'hFC00;
  localparam logic [15:0] E3_1 = 16'hFF80;
  localparam logic [15:0] E5_0 = 16'h8000;
  localparam logic [15:0] E6_0 = 16'hFFFF;
`endif

  typedef struct packed {
    logic [3:0][15:0] x;
    logic [3:0][15:0] w0;
    logic [3:0][15:0] w1;
    logic [15:0]      b0;
    logic [15:0]      b1;
    logic [15:0]      e0;
    logic [15:0]      e1;
    logic             gaps;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0][15:0] cur_w0, cur_w1;
  logic [15:0] cur_b0, cur_b1;
  int n_pass = 0;
  int n_tot  = 0;
  vec_t vt [7];

  pointwise_conv_engine_if #(.DSP_NO(DSP_NO), .CHIN(CHIN), .WIDTH(WIDTH)) bus ();

  pointwise_conv_engine #(
    .DSP_NO(DSP_NO), .CHIN(CHIN), .PIXELS(PIXELS), .WIDTH(WIDTH), .FRAC(FRAC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Combinational weight ROM and static bias
  always_comb begin
    bus.w_data[0] = cur_w0[bus.w_addr];
    bus.w_data[1] = cur_w1[bus.w_addr];
    bus.bias[0]   = cur_b0;
    bus.bias[1]   = cur_b1;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [3:0][15:0] rep4(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},      16'(bus.busy), 16'h0000);
    chk({tag, "_ifm_ready"}, 16'(bus.ifm_ready), 16'h0000);
    chk({tag, "_ofm_valid"}, 16'(bus.ofm_valid), 16'h0000);
    chk({tag, "_done"},      16'(bus.done), 16'h0000);
    chk({tag, "_w_addr"},    16'(bus.w_addr), 16'h0000);
    chk({tag, "_ofm0"},      bus.ofm[0], 16'h0000);
    chk({tag, "_ofm1"},      bus.ofm[1], 16'h0000);
  endtask

  task automatic beat(input logic [15:0] x);
    bus.ifm = x;
    bus.ifm_valid = 1'b1;
    @(negedge clk);
    bus.ifm_valid = 1'b0;
  endtask

  // One full layer; each call begins and ends on a falling edge
  task automatic run_layer(input vec_t v, input int stall, input bit poke);
    cur_w0 = v.w0; cur_w1 = v.w1; cur_b0 = v.b0; cur_b1 = v.b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 16'(bus.busy), 16'h0001);
    chk("ready_in_acc", 16'(bus.ifm_ready), 16'h0001);
    for (int px = 0; px < PIXELS; px++) begin
      for (int ch = 0; ch < CHIN; ch++) begin
        if (v.gaps) begin
          bus.ifm = 16'h7FFF;
          @(negedge clk);
        end
        chk("w_addr", 16'(bus.w_addr), 16'(ch));
        bus.start = poke && (ch == 1);
        beat(v.x[ch]);
        bus.start = 1'b0;
      end
      chk("ofm_valid_latency", 16'(bus.ofm_valid), 16'h0001);
      chk("ready_in_out", 16'(bus.ifm_ready), 16'h0000);
      chk("w_addr_out", 16'(bus.w_addr), 16'h0000);
      chk("ofm0", bus.ofm[0], v.e0);
      chk("ofm1", bus.ofm[1], v.e1);
      if (stall > 0 && px == 0) begin
        bus.ifm_valid = 1'b1;
        bus.ifm = 16'h7FFF;
        for (int k = 0; k < stall; k++) begin
          @(negedge clk);
          chk("stall_valid", 16'(bus.ofm_valid), 16'h0001);
          chk("stall_ready", 16'(bus.ifm_ready), 16'h0000);
          chk("stall_ofm0", bus.ofm[0], v.e0);
        end
        bus.ifm_valid = 1'b0;
      end
      bus.ofm_ready = 1'b1;
      @(negedge clk);
      bus.ofm_ready = 1'b0;
      chk("ofm_valid_drop", 16'(bus.ofm_valid), 16'h0000);
      if (px < PIXELS-1) begin
        chk("ready_next_px", 16'(bus.ifm_ready), 16'h0001);
        chk("no_early_done", 16'(bus.done), 16'h0000);
      end else begin
        chk("done_pulse", 16'(bus.done), 16'h0001);
        chk("busy_in_fin", 16'(bus.busy), 16'h0001);
        @(negedge clk);
        chk("done_single", 16'(bus.done), 16'h0000);
        chk("busy_end", 16'(bus.busy), 16'h0000);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.ifm = 16'h0000; bus.ifm_valid = 1'b0; bus.ofm_ready = 1'b0;
    cur_w0 = rep4(16'h0000); cur_w1 = rep4(16'h0000); cur_b0 = 16'h0000; cur_b1 = 16'h0000;

    vt[0] = '{x: rep4(16'h0100), w0: rep4(16'h0100), w1: rep4(16'h0100),
              b0: 16'h0100, b1: 16'h0100, e0: 16'h0500, e1: 16'h0500, gaps: 1'b0};
    vt[1] = '{x: rep4(16'h0100), w0: rep4(16'hFF00), w1: rep4(16'h0100),
              b0: 16'h0000, b1: 16'h0000, e0: E1_0, e1: 16'h0400, gaps: 1'b0};
    vt[2] = '{x: rep4(16'h7FFF), w0: rep4(16'h7FFF), w1: rep4(16'h7FFF),
              b0: 16'h0100, b1: 16'h0100, e0: 16'h7FFF, e1: 16'h7FFF, gaps: 1'b0};
    vt[3] = '{x: {16'h0040, 16'hFF00, 16'h0080, 16'h0200},
              w0: {16'h0400, 16'h0300, 16'h0200, 16'h0100},
              w1: {16'hFC00, 16'h0000, 16'h0100, 16'h0000},
              b0: 16'h0080, b1: 16'h0000, e0: 16'h0180, e1: E3_1, gaps: 1'b1};
    vt[4] = vt[3];
    vt[4].gaps = 1'b0;
    vt[5] = '{x: rep4(16'h8000), w0: rep4(16'h7FFF), w1: rep4(16'h8000),
              b0: 16'h0000, b1: 16'h0000, e0: E5_0, e1: 16'h7FFF, gaps: 1'b0};
    vt[6] = '{x: rep4(16'h0001), w0: rep4(16'hFFFF), w1: rep4(16'h0001),
              b0: 16'h0000, b1: 16'h0000, e0: E6_0, e1: 16'h0000, gaps: 1'b0};

    #12;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_layer(vt[i], 0, i == 1);

    // Back-pressure: five stalled cycles in OUT with junk ifm offered
    run_layer(vt[4], 5, 1'b0);

    // Asynchronous reset in the middle of pixel 1
    cur_w0 = vt[0].w0; cur_w1 = vt[0].w1; cur_b0 = vt[0].b0; cur_b1 = vt[0].b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int ch = 0; ch < CHIN; ch++) beat(16'h0100);
    chk("prereset_ofm0", bus.ofm[0], 16'h0500);
    bus.ofm_ready = 1'b1;
    @(negedge clk);
    bus.ofm_ready = 1'b0;
    beat(16'h0100);
    beat(16'h0100);
    chk("prereset_w_addr", 16'(bus.w_addr), 16'h0002);
    #2 rst = 1'b0;
    #1 chk_idle_outputs("midreset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_layer(vt[0], 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
